// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder controller: state encoding,
// default width and a width helper for the bit counter.
package serial_add_pkg;

  localparam int SA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int CLOG2(input int v);
    int r;
    int n;
    r = 0;
    n = v - 1;
    while (n > 0) begin
      r++;
      n = n >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// W-bit register with parallel load and shift-right; the fill bit enters at the MSB.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         cp,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         fill,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load)       data_d = load_val;
    else if (shift) data_d = {fill, data_q[W-1:1]};
  end

  always_ff @(posedge cp) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Serializes two W-bit operands LSB-first into an external full-adder cell,
// owns its carry flop and collects the serial sum back into a W-bit word.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = SA_W
) (
  input  logic         cp,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         x1,
  output logic         x2,
  output logic         y,
  input  logic         ny,
  input  logic         z,
  output logic         out_valid,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CNT_W = CLOG2(W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             cout_q, cout_d;
  logic [W-1:0]     sa_q, sb_q, ssum_q;
  logic             accept, shifting, last;
  logic             unused_hi;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign shifting = (state_q == S_SHIFT);
  assign last     = shifting && (cnt_q == CNT_W'(W - 1));

  serial_shift_reg #(.W(W)) u_sa (
    .cp(cp), .rst(rst), .load(accept), .load_val(a),
    .shift(shifting), .fill(1'b0), .q(sa_q)
  );

  serial_shift_reg #(.W(W)) u_sb (
    .cp(cp), .rst(rst), .load(accept), .load_val(b),
    .shift(shifting), .fill(1'b0), .q(sb_q)
  );

  // Sum is never parallel-loaded; it keeps the previous result until the next SHIFT.
  serial_shift_reg #(.W(W)) u_ssum (
    .cp(cp), .rst(rst), .load(1'b0), .load_val('0),
    .shift(shifting), .fill(z), .q(ssum_q)
  );

  // Only the LSBs feed the cell; upper bits exist purely to be shifted down.
  assign unused_hi = ^{sa_q[W-1:1], sb_q[W-1:1]};

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SHIFT;
      S_SHIFT: if (last)     state_d = S_DONE;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Carry is cleared at acceptance so nothing leaks between back-to-back ops.
  always_comb begin
    cnt_d  = cnt_q;
    y_d    = y_q;
    cout_d = cout_q;
    if (accept) begin
      cnt_d = '0;
      y_d   = 1'b0;
    end else if (shifting) begin
      cnt_d = cnt_q + 1'b1;
      y_d   = ny;
      if (last) cout_d = ny;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign x1   = sa_q[0];
  assign x2   = sb_q[0];
  assign y    = y_q;
  assign sum  = ssum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench: closes the loop with a behavioural full-adder cell and scoreboards every result.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         cp = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, x1, x2, y, ny, z, out_valid, cout;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  serial_add_ctrl #(.W(W)) dut (
    .cp(cp), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .x1(x1), .x2(x2), .y(y), .ny(ny), .z(z),
    .out_valid(out_valid), .sum(sum), .cout(cout)
  );

  assign z  = x1 ^ x2 ^ y;
  assign ny = (x1 & x2) | (x1 & y) | (x2 & y);

  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0] s;
    exp_t       e;
    s      = {1'b0, av} + {1'b0, bv};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    sb_q.push_back(e);
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    @(posedge cp);
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("sb_sum", sum, e.sum);
        chk("sb_cout", cout, e.cout);
      end
    end
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic [W-1:0] exp_sum, input logic exp_cout,
                    output logic [W:1] ys);
    in_valid = 1'b1;
    a = av;
    b = bv;
    chk("in_ready_pre", in_ready, 1);
    tick();
    push(av, bv);
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk("x1_bit", x1, av[k-1]);
      chk("x2_bit", x2, bv[k-1]);
      chk("no_early_valid", out_valid, 0);
      ys[k] = y;
      tick();
    end
    chk("done_valid", out_valid, 1);
    chk("done_sum", sum, exp_sum);
    chk("done_cout", cout, exp_cout);
    tick();
    chk("post_ready", in_ready, 1);
    chk("post_valid", out_valid, 0);
    chk("post_x1", x1, 0);
  endtask

  initial begin
    logic [W:1] ys;
    int n;

    // 1. reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_x1", x1, 0);
    chk("rst_x2", x2, 0);
    chk("rst_y", y, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) tick();

    // 2. basic add
    op(8'h5A, 8'h3C, 8'h96, 1'b0, ys);

    // 3. carry ripples through every bit
    op(8'hFF, 8'h01, 8'h00, 1'b1, ys);
    chk("ripple_y", {24'b0, ys}, 32'h0000_00FE);

    // 4. back-to-back with carry isolation
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    tick();
    push(8'hFF, 8'hFF);
    a = 8'h00;
    b = 8'h00;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_spacing", n + 1, 10);
    chk("b2b_first_sum", sum, 8'hFE);
    chk("b2b_first_cout", cout, 1);
    tick();
    push(8'h00, 8'h00);
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk("b2b_y_zero", y, 0);
      tick();
    end
    chk("b2b_valid", out_valid, 1);
    chk("b2b_sum", sum, 8'h00);
    chk("b2b_cout", cout, 0);
    tick();

    // 5. in_valid mid-operation is ignored
    in_valid = 1'b1;
    a = 8'h10;
    b = 8'h20;
    tick();
    push(8'h10, 8'h20);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b1;
    a = 8'h11;
    chk("ign_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    a = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    chk("ign_valid", out_valid, 1);
    chk("ign_sum", sum, 8'h30);
    for (int i = 0; i < 4; i++) tick();

    // 6. reset mid-SHIFT aborts the operation
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    tick();
    push(8'hAA, 8'h55);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk("abort_ready", in_ready, 1);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_y", y, 0);
    chk("abort_valid", out_valid, 0);
    for (int i = 0; i < 12; i++) tick();
    op(8'h01, 8'h02, 8'h03, 1'b0, ys);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Operand serializer and result collector for the team's carry-external serial full-adder cell. That cell computes z = x1^x2^y and ny = majority(x1,x2,y), and keeps its carry outside itself. This block accepts two W-bit parallel operands over a valid/ready handshake, drives them LSB-first onto x1/x2, and owns the carry flip-flop y, fed back from ny each clock. It collects z into a W-bit sum and presents sum plus carry-out with a one-cycle valid strobe. It sits between a parallel datapath and one serial adder cell.

## Interface
- W, 8, operand/sum width in bits; legal range ≥ 2.
- cp  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands a/b present.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- x1  out  1  serial bit of A to adder cell.
- x2  out  1  serial bit of B to adder cell.
- y  out  1  carry state to adder cell (registered).
- ny  in  1  next-carry from adder cell.
- z  in  1  sum bit from adder cell.
- out_valid  out  1  one-cycle strobe: sum/cout valid.
- sum  out  W  collected sum, bit 0 = first serial bit.
- cout  out  1  final carry-out.

## Operation
- Registers: state, sa[W-1:0], sb[W-1:0], ssum[W-1:0], cnt[log2(W)-1:0], y, cout_r.
- x1 = sa[0], x2 = sb[0] (combinational from shift registers).
- in_ready = (state==IDLE).
- **IDLE**:
  - If in_valid: sa<=a, sb<=b, y<=0, cnt<=0, go to SHIFT.
  - sum/cout hold their previous values.
- **SHIFT**, every cycle:
  - ssum<={z, ssum[W-1:1]}; y<=ny.
  - sa<={1'b0, sa[W-1:1]}; sb<={1'b0, sb[W-1:1]}.
  - cnt<=cnt+1.
  - When cnt==W-1: cout_r<=ny, go to DONE.
- **DONE**: out_valid=1 for this single cycle; next state IDLE. There is no backpressure on the output.
- sum = ssum, cout = cout_r. Both stay stable from DONE until the next SHIFT begins.
- The sum is W bits modulo 2^W; overflow is reported only via cout.
- x1/x2 are 0 outside SHIFT, because the shift registers are fully drained after W shifts.
- in_valid while not IDLE is ignored; a/b are sampled only at the accepting edge.

## Timing
- Reset (rst high at an edge): state=IDLE, sa=sb=ssum=0, y=0, cout_r=0, cnt=0.
  - Consequently x1=x2=0, sum=0, cout=0, out_valid=0, and in_ready=1 from the first cycle after reset.
- Reset mid-SHIFT or in DONE aborts the operation. No out_valid is issued for it; sum/cout read 0.
- Acceptance edge E0 (IDLE & in_valid).
- Cycles 1..W after E0: SHIFT. Bit i is presented in cycle i+1 and its z/ny are captured at the end of that cycle.
- Cycle W+1: DONE, out_valid=1.
- Cycle W+2: IDLE, in_ready=1.
- Minimum spacing between acceptances: W+2 cycles.
- in_valid held high continuously gives back-to-back operations at that spacing. y is cleared at every acceptance, so no carry leaks between operations.
- The adder cell is purely combinational. Its z/ny must settle within one cp period of x1/x2/y changing.

## Structure
- Shared package serial_add_pkg holds:
  - state encoding constants: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - default width SA_W=8;
  - a CLOG2 helper for cnt width.
- Sub-module serial_shift_reg (W-bit, load / shift-right-with-fill, parameter W) is instantiated three times: sa, sb, and ssum (ssum shifts z in at the MSB).
- The FSM, counter, y and cout_r live in serial_add_ctrl.
- The bench wraps serial_add_ctrl with the adder cell (or a behavioural model of it) to close the x1/x2/y ↔ ny/z loop.

## Test plan
1. Reset then idle:
   - Stimulus: rst high 2 cycles, then low with in_valid=0.
   - Required: in_ready=1, x1=x2=y=0, sum=0, cout=0, out_valid never asserts.
2. Basic add, W=8:
   - Stimulus: a=8'h5A, b=8'h3C.
   - Required: x1 sequence 0,1,0,1,1,0,1,0 and x2 sequence 0,0,1,1,1,1,0,0 over cycles 1..8. out_valid in cycle 9 only, with sum=8'h96, cout=0.
3. Carry ripple through all bits:
   - Stimulus: a=8'hFF, b=8'h01.
   - Required: y is 1 from cycle 2 through cycle 8; sum=8'h00, cout=1.
4. Back-to-back with carry isolation:
   - Stimulus: in_valid held high; first a=8'hFF, b=8'hFF, then a=8'h00, b=8'h00.
   - Required: first result sum=8'hFE, cout=1. Second acceptance exactly 10 cycles after the first. Second result sum=8'h00, cout=0, with y=0 throughout.
5. Ignored input:
   - Stimulus: in_valid pulsed with a=8'h11 in cycle 4 of an operation on a=8'h10, b=8'h20.
   - Required: result sum=8'h30; the pulse is not accepted.
6. Reset mid-SHIFT:
   - Stimulus: rst asserted in cycle 5 of an operation on a=8'hAA, b=8'h55.
   - Required: no out_valid; next cycle state IDLE, in_ready=1, sum=0, cout=0, y=0.
   - Follow-up: a fresh a=8'h01, b=8'h02 yields sum=8'h03, cout=0.
